// File: rtl/au_pkg.sv
// -----------------------------------------------------------------------------
// au_pkg -- shared types for the audio output path.
//   AuSampleWidth  : default bits per channel sample
//   au_stereo_t    : one stereo frame, left in the upper half
//   au_tx_state_e  : I2S transmitter FSM states
//   au_ws_for_slot : word-select level for a given bit slot (Philips I2S)
// -----------------------------------------------------------------------------
package au_pkg;

   localparam int unsigned AuSampleWidth = 16;

   typedef struct packed {
      logic signed [AuSampleWidth-1:0] left;
      logic signed [AuSampleWidth-1:0] right;
   } au_stereo_t;

   typedef enum logic {
      TX_IDLE,
      TX_RUN
   } au_tx_state_e;

   // WS goes high one slot before the right-channel MSB and drops one slot
   // before the next left MSB, so it always leads the data by one SCK.
   function automatic logic au_ws_for_slot(input int unsigned slot,
                                           input int unsigned width);
      return (slot >= width - 1) && (slot <= 2 * width - 2);
   endfunction

endpackage

// File: rtl/au_stereo_fifo.sv
// -----------------------------------------------------------------------------
// au_stereo_fifo -- synchronous FIFO of stereo frames, first-word fall-through.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   push_i/data_i : write request and frame (ignored when full)
//   pop_i/data_o  : read request and current head (ignored when empty)
//   full_o/empty_o/level_o : status from the registered occupancy count
// -----------------------------------------------------------------------------
module au_stereo_fifo
   import au_pkg::*;
#(
   parameter type         elem_t = au_stereo_t,
   parameter int unsigned Depth  = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         push_i,
   input  elem_t                        data_i,
   input  logic                         pop_i,
   output elem_t                        data_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(Depth+1)-1:0]   level_o
);

   localparam int unsigned PtrW   = $clog2(Depth);
   localparam int unsigned LevelW = $clog2(Depth + 1);
   localparam logic [LevelW-1:0] FullLevel = LevelW'(Depth);

   elem_t             r_mem [Depth];
   logic [PtrW-1:0]   r_wr_ptr;
   logic [PtrW-1:0]   r_rd_ptr;
   logic [LevelW-1:0] r_level;

   logic w_push;
   logic w_pop;

   assign full_o  = (r_level == FullLevel);
   assign empty_o = (r_level == '0);
   assign level_o = r_level;
   assign data_o  = r_mem[r_rd_ptr];

   // A full FIFO refuses a push even when a pop happens in the same cycle.
   assign w_push = push_i & ~full_o;
   assign w_pop  = pop_i & ~empty_o;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         // Depth is a power of two, so the pointers wrap by overflow.
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // NOTE: the storage array is deliberately not reset; the pointers and level
   // define which entries are valid, and a reset-free array maps to plain RAM.
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= data_i;
   end

endmodule

// File: rtl/au_i2s_tx.sv
// -----------------------------------------------------------------------------
// au_i2s_tx -- Philips I2S stereo transmitter with a small frame FIFO.
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   enable_i           : transmit enable (a running frame always completes)
//   sample_i, valid_i  : {left, right} frame and its valid strobe
//   ready_o            : FIFO has room (registered level only)
//   fifo_level_o       : FIFO occupancy
//   underrun_o         : one-cycle pulse when a frame starts with an empty FIFO
//   i2s_sck_o/ws_o/sd_o: bit clock, word select (0 = left), serial data
// Data and WS change together with the SCK falling edge; the receiver samples
// on the rising edge.
// -----------------------------------------------------------------------------
module au_i2s_tx
   import au_pkg::*;
#(
   parameter int unsigned DataWidth = AuSampleWidth,
   parameter int unsigned ClkDiv    = 4,
   parameter int unsigned FifoDepth = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             enable_i,
   input  logic [2*DataWidth-1:0]           sample_i,
   input  logic                             valid_i,
   output logic                             ready_o,
   output logic [$clog2(FifoDepth+1)-1:0]   fifo_level_o,
   output logic                             underrun_o,
   output logic                             i2s_sck_o,
   output logic                             i2s_ws_o,
   output logic                             i2s_sd_o
);

   localparam int unsigned FrameW = 2 * DataWidth;
   localparam int unsigned DivW   = $clog2(ClkDiv);
   localparam int unsigned SlotW  = $clog2(FrameW);
   localparam logic [DivW-1:0]  DivLast  = DivW'(ClkDiv - 1);
   localparam logic [SlotW-1:0] SlotLast = SlotW'(FrameW - 1);

   typedef struct packed {
      logic signed [DataWidth-1:0] left;
      logic signed [DataWidth-1:0] right;
   } stereo_t;

   au_tx_state_e      r_state;
   logic [DivW-1:0]   r_div;
   logic              r_sck;
   logic [SlotW-1:0]  r_slot;
   logic [FrameW-1:0] r_shift;
   logic              r_sd;
   logic              r_ws;
   logic              r_underrun;

   au_tx_state_e      w_state_nxt;
   logic [DivW-1:0]   w_div_nxt;
   logic              w_sck_nxt;
   logic [SlotW-1:0]  w_slot_nxt;
   logic [FrameW-1:0] w_shift_nxt;
   logic              w_sd_nxt;
   logic              w_ws_nxt;
   logic              w_underrun_nxt;
   logic              w_frame_start;
   logic              w_pop;
   logic [FrameW-1:0] w_word;

   logic              w_full;
   logic              w_empty;
   stereo_t           w_head;

   assign ready_o = ~w_full;

   au_stereo_fifo #(
      .elem_t (stereo_t),
      .Depth  (FifoDepth)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (valid_i & ready_o),
      .data_i  (stereo_t'(sample_i)),
      .pop_i   (w_pop),
      .data_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty),
      .level_o (fifo_level_o)
   );

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt    = r_state;
      w_div_nxt      = r_div;
      w_sck_nxt      = r_sck;
      w_slot_nxt     = r_slot;
      w_shift_nxt    = r_shift;
      w_sd_nxt       = r_sd;
      w_ws_nxt       = r_ws;
      w_underrun_nxt = 1'b0;
      w_frame_start  = 1'b0;
      w_pop          = 1'b0;
      w_word         = '0;

      unique case (r_state)
         TX_IDLE: begin
            w_div_nxt  = '0;
            w_sck_nxt  = 1'b0;
            w_slot_nxt = '0;
            w_sd_nxt   = 1'b0;
            w_ws_nxt   = 1'b0;
            // Entering RUN counts as the first falling-edge event (slot 0).
            if (enable_i) begin
               w_state_nxt   = TX_RUN;
               w_frame_start = 1'b1;
            end
         end
         TX_RUN: begin
            if (r_div == DivLast) begin
               w_div_nxt = '0;
               w_sck_nxt = ~r_sck;
               if (r_sck) begin
                  // Falling-edge event: move to the next slot.
                  if (r_slot == SlotLast) begin
                     w_slot_nxt = '0;
                     if (enable_i) begin
                        w_frame_start = 1'b1;
                     end else begin
                        // Stop at the frame boundary; the FIFO head stays put.
                        w_state_nxt = TX_IDLE;
                        w_sd_nxt    = 1'b0;
                        w_ws_nxt    = 1'b0;
                     end
                  end else begin
                     w_slot_nxt  = r_slot + 1'b1;
                     w_sd_nxt    = r_shift[FrameW-1];
                     w_shift_nxt = {r_shift[FrameW-2:0], 1'b0};
                     w_ws_nxt    = au_ws_for_slot(32'(w_slot_nxt), DataWidth);
                  end
               end
            end else begin
               w_div_nxt = r_div + 1'b1;
            end
         end
      endcase

      // Slot 0: load the next frame, or zeros with an underrun pulse.
      if (w_frame_start) begin
         w_pop          = ~w_empty;
         w_underrun_nxt = w_empty;
         if (!w_empty) w_word = w_head;
         w_slot_nxt     = '0;
         w_sd_nxt       = w_word[FrameW-1];
         w_shift_nxt    = {w_word[FrameW-2:0], 1'b0};
         w_ws_nxt       = au_ws_for_slot(32'd0, DataWidth);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state    <= TX_IDLE;
         r_div      <= '0;
         r_sck      <= 1'b0;
         r_slot     <= '0;
         r_shift    <= '0;
         r_sd       <= 1'b0;
         r_ws       <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_div      <= w_div_nxt;
         r_sck      <= w_sck_nxt;
         r_slot     <= w_slot_nxt;
         r_shift    <= w_shift_nxt;
         r_sd       <= w_sd_nxt;
         r_ws       <= w_ws_nxt;
         r_underrun <= w_underrun_nxt;
      end
   end

   assign i2s_sck_o  = r_sck;
   assign i2s_ws_o   = r_ws;
   assign i2s_sd_o   = r_sd;
   assign underrun_o = r_underrun;

endmodule

// File: tb/tb_au_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_au_i2s_tx -- self-checking bench for au_i2s_tx (DataWidth=16, ClkDiv=4,
// FifoDepth=4). A frame-level reference model predicts every output each
// cycle from the elapsed cycle count since the frame started; an I2S receiver
// rebuilds transmitted words on SCK rising edges for in-order delivery checks.
// -----------------------------------------------------------------------------
module tb_au_i2s_tx;

   localparam int DW        = 16;
   localparam int CLK_DIV   = 4;
   localparam int DEPTH     = 4;
   localparam int SLOTS     = 2 * DW;
   localparam int BIT_CYC   = 2 * CLK_DIV;
   localparam int FRAME_CYC = SLOTS * BIT_CYC;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic          valid;
   logic [31:0]   sample;
   logic          ready;
   logic [2:0]    level;
   logic          underrun;
   logic          sck;
   logic          ws;
   logic          sd;

   always #5 clk = ~clk;

   au_i2s_tx #(
      .DataWidth (DW),
      .ClkDiv    (CLK_DIV),
      .FifoDepth (DEPTH)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .enable_i     (enable),
      .sample_i     (sample),
      .valid_i      (valid),
      .ready_o      (ready),
      .fifo_level_o (level),
      .underrun_o   (underrun),
      .i2s_sck_o    (sck),
      .i2s_ws_o     (ws),
      .i2s_sd_o     (sd)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model (frame-level arithmetic) ----------------
   bit          m_run      = 1'b0;
   int          m_n        = 0;      // cycles since the current frame started
   logic [31:0] m_cur      = '0;     // frame being sent
   bit          m_under    = 1'b0;   // current frame started with an empty FIFO
   bit          m_was_reset = 1'b0;
   logic [31:0] m_q[$];              // accepted but not yet sent
   logic [31:0] m_frames[$];         // every frame started, in order

   always @(posedge clk) begin
      bit can_push;
      bit start;
      start = 1'b0;
      m_was_reset = !rst_n;
      if (!rst_n) begin
         m_run = 1'b0;
         m_n   = 0;
         m_cur = '0;
         m_under = 1'b0;
         m_q.delete();
      end else begin
         can_push = (m_q.size() != DEPTH);
         if (!m_run) begin
            if (enable) begin
               m_run = 1'b1;
               m_n   = 0;
               start = 1'b1;
            end
         end else begin
            m_n++;
            if (m_n == FRAME_CYC) begin
               m_n = 0;
               if (enable) start = 1'b1;
               else m_run = 1'b0;
            end
         end
         if (start) begin
            if (m_q.size() > 0) begin
               m_cur   = m_q.pop_front();
               m_under = 1'b0;
            end else begin
               m_cur   = '0;
               m_under = 1'b1;
            end
            m_frames.push_back(m_cur);
         end
         if (valid && can_push) m_q.push_back(sample);
      end
   end

   // {ready, level, sck, ws, sd, underrun} expected after the last edge.
   function automatic logic [7:0] exp_vec();
      logic e_sck, e_ws, e_sd, e_und;
      int   p;
      e_sck = 1'b0; e_ws = 1'b0; e_sd = 1'b0; e_und = 1'b0;
      if (m_run) begin
         p     = (m_n / BIT_CYC) % SLOTS;
         e_sck = (m_n % BIT_CYC) >= CLK_DIV;
         e_sd  = m_cur[SLOTS-1-p];
         e_ws  = (p >= DW - 1) && (p <= 2 * DW - 2);
         e_und = (m_n == 0) && m_under;
      end
      return {m_q.size() != DEPTH, 3'(m_q.size()), e_sck, e_ws, e_sd, e_und};
   endfunction

   // ---------------- per-cycle compare and I2S receiver ----------------
   logic        prev_sck = 1'b0;
   logic [31:0] rx_bits  = '0;
   int          rx_cnt   = 0;
   logic [31:0] rx_q[$];
   int          under_seen = 0;

   always @(negedge clk) begin
      check("cycle", {ready, level, sck, ws, sd, underrun}, exp_vec());
      if (m_was_reset) begin
         rx_cnt   = 0;
         prev_sck = 1'b0;
      end else begin
         if (sck === 1'b1 && prev_sck === 1'b0) begin
            rx_bits = {rx_bits[30:0], sd};
            rx_cnt++;
            if (rx_cnt == SLOTS) begin
               rx_q.push_back(rx_bits);
               rx_cnt = 0;
            end
         end
         prev_sck = sck;
         if (underrun === 1'b1) under_seen++;
      end
   end

   function automatic logic [31:0] rx_word(input int idx);
      return (idx < rx_q.size()) ? rx_q[idx] : 32'hxxxx_xxxx;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic push_word(input logic [31:0] w);
      bit done;
      done   = 1'b0;
      valid  = 1'b1;
      sample = w;
      for (int i = 0; i < 2000 && !done; i++) begin
         if (ready === 1'b1) done = 1'b1;
         @(negedge clk);
      end
      valid = 1'b0;
      check("push_accepted", done, 1);
   endtask

   task automatic wait_model_n(input int target);
      int i;
      i = 0;
      while (!(m_run && m_n == target) && i < 2000) begin
         @(negedge clk);
         i++;
      end
      check("wait_slot_in_time", i < 2000, 1);
   endtask

   task automatic wait_idle();
      int i;
      i = 0;
      while (m_run && i < 2000) begin
         @(negedge clk);
         i++;
      end
      check("idle_in_time", i < 2000, 1);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w[5];
      int base, ubase, fbase, nfr;

      rst_n = 1'b0; enable = 1'b0; valid = 1'b0; sample = '0;

      // Reset held for three cycles.
      repeat (3) @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_level", level, 0);
      check("rst_sck", sck, 0);
      check("rst_ws", ws, 0);
      check("rst_sd", sd, 0);
      check("rst_underrun", underrun, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // One known frame, enable pulsed so exactly one frame is sent.
      base = rx_q.size(); ubase = under_seen;
      push_word(32'hA5F0_0F0F);
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      wait_idle();
      check("known_frame_count", rx_q.size() - base, 1);
      check("known_frame_bits", rx_word(base), 32'hA5F0_0F0F);
      check("known_no_underrun", under_seen - ubase, 0);
      check("known_idle_pins", {sck, ws, sd}, 0);

      // Fill the FIFO, hold a fifth word until the first pop frees a slot.
      base = rx_q.size(); ubase = under_seen;
      for (int i = 0; i < 4; i++) begin
         w[i] = $urandom;
         push_word(w[i]);
      end
      check("full_ready", ready, 0);
      check("full_level", level, 4);
      w[4] = $urandom;
      valid = 1'b1; sample = w[4];
      @(negedge clk);
      check("full_held", level, 4);
      enable = 1'b1;
      @(negedge clk);
      check("first_pop_level", level, 3);
      @(negedge clk);
      valid = 1'b0;
      check("fifth_accepted", level, 4);
      repeat (4 * FRAME_CYC) @(negedge clk);
      enable = 1'b0;
      wait_idle();
      check("five_count", rx_q.size() - base, 5);
      for (int i = 0; i < 5; i++) check($sformatf("five_word%0d", i), rx_word(base + i), w[i]);
      check("five_no_underrun", under_seen - ubase, 0);

      // Empty FIFO: three frames of zeros, one underrun pulse each.
      base = rx_q.size(); ubase = under_seen;
      enable = 1'b1;
      repeat (2 * FRAME_CYC + 10) @(negedge clk);
      enable = 1'b0;
      wait_idle();
      check("underrun_pulses", under_seen - ubase, 3);
      check("underrun_frames", rx_q.size() - base, 3);
      for (int i = 0; i < 3; i++) check($sformatf("underrun_zero%0d", i), rx_word(base + i), 0);

      // Enable dropped at slot 10: frame completes, next entry not popped.
      base = rx_q.size();
      w[0] = $urandom; w[1] = $urandom;
      push_word(w[0]);
      push_word(w[1]);
      enable = 1'b1;
      wait_model_n(10 * BIT_CYC);
      enable = 1'b0;
      wait_idle();
      repeat (20) @(negedge clk);
      check("stop_frame_word", rx_word(base), w[0]);
      check("stop_frame_count", rx_q.size() - base, 1);
      check("stop_level_kept", level, 1);
      check("stop_idle_pins", {sck, ws, sd}, 0);

      // Reset mid-frame at slot 20 with two entries queued.
      w[2] = $urandom; w[3] = $urandom;
      push_word(w[2]);
      push_word(w[3]);
      enable = 1'b1;
      wait_model_n(20 * BIT_CYC);
      check("pre_reset_level", level, 2);
      enable = 1'b0;
      rst_n  = 1'b0;
      @(negedge clk);
      rst_n  = 1'b1;
      check("mid_rst_pins", {sck, ws, sd, underrun}, 0);
      check("mid_rst_level", level, 0);
      check("mid_rst_ready", ready, 1);
      @(negedge clk);
      base = rx_q.size(); ubase = under_seen;
      w[4] = $urandom;
      push_word(w[4]);
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      wait_idle();
      check("post_rst_word", rx_word(base), w[4]);
      check("post_rst_count", rx_q.size() - base, 1);
      check("post_rst_no_underrun", under_seen - ubase, 0);

      // Randomized traffic: bursty then sparse pushes, random enable toggling.
      base  = rx_q.size();
      fbase = m_frames.size();
      enable = 1'b1;
      for (int c = 0; c < 3600; c++) begin
         valid  = (c < 1600) ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 399) == 0);
         sample = $urandom;
         if ($urandom_range(0, 399) == 0) enable = ~enable;
         @(negedge clk);
      end
      valid  = 1'b0;
      enable = 1'b0;
      wait_idle();
      nfr = m_frames.size() - fbase;
      check("rand_frame_count", rx_q.size() - base, nfr);
      for (int i = 0; i < nfr; i++) check($sformatf("rand_word%0d", i), rx_word(base + i), m_frames[fbase + i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/au_i2s_tx.md
AU_I2S_TX -- requirements
Module: au_i2s_tx

Interface
REQ-001 SHALL have parameter DataWidth, default 16: bits per channel sample.
REQ-002 SHALL have parameter ClkDiv, default 4: clk_i cycles per SCK half-period (min 2).
REQ-003 SHALL have parameter FifoDepth, default 4: stereo frames buffered (power of two, min 2).
REQ-004 SHALL have port clk_i, input, 1: single clock.
REQ-005 SHALL have port rst_ni, input, 1: synchronous active-low reset.
REQ-006 SHALL have port enable_i, input, 1: transmit enable.
REQ-007 SHALL have port sample_i, input, 2*DataWidth: {left, right}, left in upper half, two's complement, from LPF cascade.
REQ-008 SHALL have port valid_i, input, 1: sample_i valid.
REQ-009 SHALL have port ready_o, output, 1: FIFO accepts a sample.
REQ-010 SHALL have port fifo_level_o, output, $clog2(FifoDepth+1): FIFO occupancy.
REQ-011 SHALL have port underrun_o, output, 1: one-cycle pulse at each frame sent with an empty FIFO.
REQ-012 SHALL have ports i2s_sck_o, i2s_ws_o, i2s_sd_o, output, 1 each: I2S bit clock, word select (0 = left), serial data.

Function
REQ-013 SHALL push sample_i into the FIFO on any cycle with valid_i && ready_o; ready_o = (level != FifoDepth), from the registered level only.
REQ-014 SHALL, when full, refuse a push even if a pop occurs in the same cycle; push and pop together when not full leave the level unchanged.
REQ-015 SHALL have states IDLE and RUN; IDLE->RUN when enable_i = 1.
REQ-016 SHALL treat the IDLE->RUN cycle as the first falling-edge event, slot p = 0.
REQ-017 SHALL in RUN toggle i2s_sck_o every ClkDiv cycles, giving an SCK period of 2*ClkDiv cycles; each 1->0 toggle is a falling-edge event.
REQ-018 SHALL advance slot p by one per falling event, p in 0..2*DataWidth-1, wrapping to 0.
REQ-019 SHALL pop the FIFO head into the shift register at each p = 0 event; if the FIFO is empty, SHALL load zeros and pulse underrun_o in that cycle.
REQ-020 SHALL drive i2s_sd_o = left[DataWidth-1-p] for p < DataWidth, else right[2*DataWidth-1-p]; MSB first.
REQ-021 SHALL drive i2s_ws_o = 1 for DataWidth-1 <= p <= 2*DataWidth-2, else 0, so WS leads the MSB by one SCK (Philips I2S).
REQ-022 SHALL update i2s_sd_o, i2s_ws_o and underrun_o only in falling-event cycles; all are registered outputs.
REQ-023 SHALL, when enable_i = 0 in RUN, finish the current frame; at the event that would start p = 0, go to IDLE without popping.
REQ-024 SHALL in IDLE hold i2s_sck_o, i2s_ws_o and i2s_sd_o at 0 while still accepting pushes.
REQ-025 SHALL send every accepted sample exactly once, in order, with no drop and no duplication.

Reset
REQ-026 SHALL on rst_ni = 0 at a clk_i edge enter IDLE, empty the FIFO, and clear the divider, slot and shift registers.
REQ-027 SHALL after reset drive ready_o = 1, fifo_level_o = 0, underrun_o = 0 and all I2S outputs 0, including a reset issued mid-frame.

Structure
REQ-028 SHALL take DataWidth's default from au_pkg::AuSampleWidth; au_pkg SHALL hold the typedef au_stereo_t, a struct of left and right samples.
REQ-029 SHALL instantiate one sub-module au_stereo_fifo: synchronous FIFO of au_stereo_t with push/pop/full/empty/level.
REQ-030 SHALL keep the divider, slot counter, FSM and shifter in au_i2s_tx.

Verification (DataWidth=16, ClkDiv=4, FifoDepth=4)
REQ-031 SHALL check: reset asserted 3 cycles -> ready_o=1, fifo_level_o=0, sck/ws/sd/underrun_o all 0.
REQ-032 SHALL check: push 0xA5F0_0F0F, then enable_i=1 -> frame of 256 cycles; SD bits 1010010111110000 then 0000111100001111; WS rises at the left LSB slot (p=15); underrun_o stays 0.
REQ-033 SHALL check: 5 consecutive pushes with enable_i=0 -> ready_o=0 after the 4th; the 5th is held until the first p=0 pop, then accepted; all 5 are transmitted in order.
REQ-034 SHALL check: enable_i=1 with an empty FIFO -> all-zero SD and a 1-cycle underrun_o pulse every 256 cycles.
REQ-035 SHALL check: enable_i dropped at p=10 -> frame completes through p=31, then IDLE with sck=ws=sd=0 and the next FIFO entry not popped.
REQ-036 SHALL check: rst_ni pulsed at p=20 with level=2 -> next cycle all outputs 0, level=0; re-enable starts a clean frame at p=0.
